mem_access_arbiter: RTL and testbench

Sequences the single shared memory port between instruction fetch (PC-addressed, into IR) and data access (RZ address, RM write data, MEM_Data_Out read data into MuxY). It owns MEM_Address, MEM_Data_In and MEM_r_w_z_z, and runs the MEM_MFC/MEM_ERROR handshake. It adds a bus timeout, and returns a one-cycle Ack plus captured read data to the granted requester. It sits between the processor top level and the memory interface, replacing the direct MuxMA drive.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_timeout_counter.sv | 35 +++
 rtl/mem_access_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state, bus-operation, error-cause and grant encodings for the memory access arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } arb_state_e;

    localparam logic [1:0] MEM_OP_READ  = 2'b00;
    localparam logic [1:0] MEM_OP_WRITE = 2'b01;
    localparam logic [1:0] MEM_OP_HIZ   = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_MEM     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_timeout_counter.sv
// Counts ACCESS cycles for the memory arbiter; expired_o flags the last permitted cycle.
module mem_arb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one memory port between instruction fetch and data access with a bus timeout.
// Optional round-robin tie-break on simultaneous requests: define MEM_ARB_ROUND_ROBIN_EN.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Fetch_Req,
    input  logic [ADDR_W-1:0] Fetch_Address,
    output logic              Fetch_Ack,
    input  logic              Data_Req,
    input  logic              Data_Write,
    input  logic [ADDR_W-1:0] Data_Address,
    input  logic [DATA_W-1:0] Data_Wdata,
    output logic              Data_Ack,
    output logic [DATA_W-1:0] Rsp_Data,
    output logic              Rsp_Err,
    output logic [ADDR_W-1:0] MEM_Address,
    output logic [DATA_W-1:0] MEM_Data_In,
    output logic [1:0]        MEM_r_w_z_z,
    input  logic [DATA_W-1:0] MEM_Data_Out,
    input  logic              MEM_MFC,
    input  logic              MEM_ERROR,
    output logic              Busy,
    output logic              Error_Flag,
    output logic [1:0]        Error_Cause,
    output logic [ADDR_W-1:0] Error_Address
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        mem_op_q, mem_op_d;
    logic              fetch_ack_q, fetch_ack_d;
    logic              data_ack_q, data_ack_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              busy_q, busy_d;
    logic              err_flag_q, err_flag_d;
    logic [1:0]        err_cause_q, err_cause_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              win;
    logic              done;
    logic              fail;
    logic [1:0]        cause;
    logic              timeout_expired;

    mem_arb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (Clock),
        .rst_ni   (Reset_n),
        .clear_i  (state_q != ACCESS),
        .enable_i (state_q == ACCESS),
        .expired_o(timeout_expired)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // On a tie the requester that did not win last time goes first.
    assign win = (Fetch_Req && Data_Req)
                 ? ((last_grant_q == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA)
                 : (Data_Req ? GRANT_DATA : GRANT_FETCH);

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (Fetch_Req || Data_Req)) begin
            last_grant_d = win;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            last_grant_q <= GRANT_FETCH;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign win = Data_Req ? GRANT_DATA : GRANT_FETCH;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_op_d    = mem_op_q;
        fetch_ack_d = 1'b0;
        data_ack_d  = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        err_flag_d  = err_flag_q;
        err_cause_d = err_cause_q;
        err_addr_d  = err_addr_q;
        done        = 1'b0;
        fail        = 1'b0;
        cause       = ERR_NONE;

        case (state_q)
            IDLE: begin
                if (Fetch_Req || Data_Req) begin
                    state_d = ACCESS;
                    grant_d = win;
                    if (win == GRANT_DATA) begin
                        mem_addr_d  = Data_Address;
                        mem_wdata_d = Data_Wdata;
                        mem_op_d    = Data_Write ? MEM_OP_WRITE : MEM_OP_READ;
                    end else begin
                        mem_addr_d = Fetch_Address;
                        mem_op_d   = MEM_OP_READ;
                    end
                end
            end
            ACCESS: begin
                // An address fault outranks a completion reported in the same cycle.
                if (MEM_ERROR) begin
                    done  = 1'b1;
                    fail  = 1'b1;
                    cause = ERR_MEM;
                end else if (MEM_MFC) begin
                    done = 1'b1;
                    if (mem_op_q == MEM_OP_READ) begin
                        rsp_data_d = MEM_Data_Out;
                    end
                end else if (timeout_expired) begin
                    done  = 1'b1;
                    fail  = 1'b1;
                    cause = ERR_TIMEOUT;
                end
                if (done) begin
                    state_d     = RESP;
                    mem_op_d    = MEM_OP_HIZ;
                    rsp_err_d   = fail;
                    fetch_ack_d = (grant_q == GRANT_FETCH);
                    data_ack_d  = (grant_q == GRANT_DATA);
                    if (fail && !err_flag_q) begin
                        err_flag_d  = 1'b1;
                        err_cause_d = cause;
                        err_addr_d  = mem_addr_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_op_d = MEM_OP_HIZ;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            grant_q     <= GRANT_FETCH;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_op_q    <= MEM_OP_HIZ;
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_flag_q  <= 1'b0;
            err_cause_q <= ERR_NONE;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_op_q    <= mem_op_d;
            fetch_ack_q <= fetch_ack_d;
            data_ack_q  <= data_ack_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
            err_flag_q  <= err_flag_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign Fetch_Ack     = fetch_ack_q;
    assign Data_Ack      = data_ack_q;
    assign Rsp_Data      = rsp_data_q;
    assign Rsp_Err       = rsp_err_q;
    assign MEM_Address   = mem_addr_q;
    assign MEM_Data_In   = mem_wdata_q;
    assign MEM_r_w_z_z   = mem_op_q;
    assign Busy          = busy_q;
    assign Error_Flag    = err_flag_q;
    assign Error_Cause   = err_cause_q;
    assign Error_Address = err_addr_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus randomized transactions
// compared against a transaction-level reference model.
module tb_mem_access_arbiter;
    import mem_arb_pkg::*;

    localparam int TIMEOUT = 16;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Fetch_Req;
    logic [31:0] Fetch_Address;
    logic        Fetch_Ack;
    logic        Data_Req;
    logic        Data_Write;
    logic [31:0] Data_Address;
    logic [31:0] Data_Wdata;
    logic        Data_Ack;
    logic [31:0] Rsp_Data;
    logic        Rsp_Err;
    logic [31:0] MEM_Address;
    logic [31:0] MEM_Data_In;
    logic [1:0]  MEM_r_w_z_z;
    logic [31:0] MEM_Data_Out;
    logic        MEM_MFC;
    logic        MEM_ERROR;
    logic        Busy;
    logic        Error_Flag;
    logic [1:0]  Error_Cause;
    logic [31:0] Error_Address;

    int checks = 0;
    int errors = 0;

    logic [31:0] mRspData;
    bit          mErrFlag;
    logic [1:0]  mErrCause;
    logic [31:0] mErrAddr;
    bit          mLastData;

    mem_access_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Fetch_Req    (Fetch_Req),
        .Fetch_Address(Fetch_Address),
        .Fetch_Ack    (Fetch_Ack),
        .Data_Req     (Data_Req),
        .Data_Write   (Data_Write),
        .Data_Address (Data_Address),
        .Data_Wdata   (Data_Wdata),
        .Data_Ack     (Data_Ack),
        .Rsp_Data     (Rsp_Data),
        .Rsp_Err      (Rsp_Err),
        .MEM_Address  (MEM_Address),
        .MEM_Data_In  (MEM_Data_In),
        .MEM_r_w_z_z  (MEM_r_w_z_z),
        .MEM_Data_Out (MEM_Data_Out),
        .MEM_MFC      (MEM_MFC),
        .MEM_ERROR    (MEM_ERROR),
        .Busy         (Busy),
        .Error_Flag   (Error_Flag),
        .Error_Cause  (Error_Cause),
        .Error_Address(Error_Address)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mRspData  = '0;
        mErrFlag  = 1'b0;
        mErrCause = ERR_NONE;
        mErrAddr  = '0;
        mLastData = 1'b0;
    endtask

    function automatic bit expectWinnerData(input bit fReq, input bit dReq);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (fReq && dReq) return !mLastData;
`endif
        return dReq;
    endfunction

    task automatic checkErrorRegs(input string tag);
        checkOutput({tag, "_err_flag"}, Error_Flag, mErrFlag);
        checkOutput({tag, "_err_cause"}, Error_Cause, mErrCause);
        checkOutput({tag, "_err_addr"}, Error_Address, mErrAddr);
    endtask

    // Entered at a negedge with the DUT idle and the winner's request already driven.
    // waits < 0 means memory never answers; memErr raises MEM_ERROR together with MFC.
    task automatic runAccess(input bit isData, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int waits, input bit memErr,
                             input logic [31:0] rdata, input bit dropEarly, input string tag);
        int         cyc = 0;
        bit         gotAck = 1'b0;
        bit         ok;
        bit         fail;
        int         expAck;
        logic [1:0] expOp;
        ok     = (waits >= 0 && waits < TIMEOUT);
        fail   = !ok || memErr;
        expAck = ok ? waits + 2 : TIMEOUT + 1;
        expOp  = (isData && wr) ? MEM_OP_WRITE : MEM_OP_READ;
        MEM_MFC      = 1'b0;
        MEM_ERROR    = 1'b0;
        MEM_Data_Out = rdata;
        mLastData    = isData;
        while (!gotAck && cyc < TIMEOUT + 8) begin
            @(negedge Clock);
            cyc++;
            if (Fetch_Ack || Data_Ack) begin
                gotAck = 1'b1;
            end else begin
                checkOutput({tag, "_op"}, MEM_r_w_z_z, expOp);
                checkOutput({tag, "_busy"}, Busy, 1'b1);
                if (cyc == 1) begin
                    checkOutput({tag, "_addr"}, MEM_Address, addr);
                    if (isData && wr) checkOutput({tag, "_wdata"}, MEM_Data_In, wdata);
                    if (dropEarly) begin
                        if (isData) Data_Req = 1'b0;
                        else Fetch_Req = 1'b0;
                    end
                end
                MEM_MFC   = (waits >= 0 && cyc - 1 == waits);
                MEM_ERROR = memErr && MEM_MFC;
            end
        end
        checkOutput({tag, "_ack_seen"}, gotAck, 1'b1);
        checkOutput({tag, "_latency"}, cyc, expAck);
        checkOutput({tag, "_fetch_ack"}, Fetch_Ack, !isData);
        checkOutput({tag, "_data_ack"}, Data_Ack, isData);
        if (!fail && !(isData && wr)) mRspData = rdata;
        if (fail && !mErrFlag) begin
            mErrFlag  = 1'b1;
            mErrCause = memErr ? ERR_MEM : ERR_TIMEOUT;
            mErrAddr  = addr;
        end
        checkOutput({tag, "_rsp_err"}, Rsp_Err, fail);
        checkOutput({tag, "_rsp_data"}, Rsp_Data, mRspData);
        checkOutput({tag, "_resp_op"}, MEM_r_w_z_z, MEM_OP_HIZ);
        if (isData) Data_Req = 1'b0;
        else Fetch_Req = 1'b0;
        MEM_MFC   = 1'b0;
        MEM_ERROR = 1'b0;
        @(negedge Clock);
        checkOutput({tag, "_idle_busy"}, Busy, 1'b0);
        checkOutput({tag, "_idle_fack"}, Fetch_Ack, 1'b0);
        checkOutput({tag, "_idle_dack"}, Data_Ack, 1'b0);
        checkOutput({tag, "_idle_op"}, MEM_r_w_z_z, MEM_OP_HIZ);
        checkErrorRegs(tag);
    endtask

    task automatic applyStimulus(input bit isData, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits, input bit memErr,
                                 input logic [31:0] rdata, input bit dropEarly, input string tag);
        if (isData) begin
            Data_Req     = 1'b1;
            Data_Write   = wr;
            Data_Address = addr;
            Data_Wdata   = wdata;
        end else begin
            Fetch_Req     = 1'b1;
            Fetch_Address = addr;
        end
        runAccess(isData, wr, addr, wdata, waits, memErr, rdata, dropEarly, tag);
    endtask

    // Both requesters raise together; the model picks who goes first.
    task automatic contend(input logic [31:0] fAddr, input logic [31:0] dAddr, input bit dWr,
                           input logic [31:0] dWdata, input int waits, input string tag);
        bit dataFirst;
        Fetch_Req     = 1'b1;
        Fetch_Address = fAddr;
        Data_Req      = 1'b1;
        Data_Write    = dWr;
        Data_Address  = dAddr;
        Data_Wdata    = dWdata;
        dataFirst = expectWinnerData(1'b1, 1'b1);
        if (dataFirst) begin
            runAccess(1'b1, dWr, dAddr, dWdata, waits, 1'b0, $urandom, 1'b0, {tag, "_first_data"});
            runAccess(1'b0, 1'b0, fAddr, '0, waits, 1'b0, $urandom, 1'b0, {tag, "_second_fetch"});
        end else begin
            runAccess(1'b0, 1'b0, fAddr, '0, waits, 1'b0, $urandom, 1'b0, {tag, "_first_fetch"});
            runAccess(1'b1, dWr, dAddr, dWdata, waits, 1'b0, $urandom, 1'b0, {tag, "_second_data"});
        end
    endtask

    initial begin
        Reset_n       = 1'b0;
        Fetch_Req     = 1'b0;
        Fetch_Address = '0;
        Data_Req      = 1'b0;
        Data_Write    = 1'b0;
        Data_Address  = '0;
        Data_Wdata    = '0;
        MEM_Data_Out  = '0;
        MEM_MFC       = 1'b0;
        MEM_ERROR     = 1'b0;
        modelReset();

        @(negedge Clock);
        checkOutput("rst_op", MEM_r_w_z_z, MEM_OP_HIZ);
        checkOutput("rst_addr", MEM_Address, 32'h0);
        checkOutput("rst_wdata", MEM_Data_In, 32'h0);
        checkOutput("rst_fack", Fetch_Ack, 1'b0);
        checkOutput("rst_dack", Data_Ack, 1'b0);
        checkOutput("rst_rsp_data", Rsp_Data, 32'h0);
        checkOutput("rst_rsp_err", Rsp_Err, 1'b0);
        checkOutput("rst_busy", Busy, 1'b0);
        checkErrorRegs("rst");
        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);

        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0, "fetch_basic");
        applyStimulus(1'b1, 1'b1, 32'h40, 32'h1234, 3, 1'b0, 32'hCAFEF00D, 1'b0, "write_wait3");
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, 1, 1'b0, 32'h5555AAAA, 1'b0, "data_read");
        contend(32'h100, 32'h200, 1'b0, 32'h0, 0, "arb_a");
        contend(32'h104, 32'h204, 1'b1, 32'h77, 2, "arb_b");

        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, -1, 1'b0, 32'h0, 1'b0, "timeout");
        checkOutput("timeout_cause", Error_Cause, ERR_TIMEOUT);
        checkOutput("timeout_addr", Error_Address, 32'h300);

        // Reset asserted during the second ACCESS cycle with the request still high.
        Fetch_Req     = 1'b1;
        Fetch_Address = 32'h500;
        @(negedge Clock);
        @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("abort_op", MEM_r_w_z_z, MEM_OP_HIZ);
        checkOutput("abort_busy", Busy, 1'b0);
        checkOutput("abort_fack", Fetch_Ack, 1'b0);
        checkErrorRegs("abort");
        @(negedge Clock);
        checkOutput("abort_hold_fack", Fetch_Ack, 1'b0);
        checkOutput("abort_hold_op", MEM_r_w_z_z, MEM_OP_HIZ);
        Reset_n = 1'b1;
        runAccess(1'b0, 1'b0, 32'h500, 32'h0, 1, 1'b0, 32'h600DF00D, 1'b0, "post_reset");

        applyStimulus(1'b1, 1'b0, 32'h7FFF, 32'h0, 0, 1'b1, 32'h11111111, 1'b0, "memerr_first");
        checkOutput("memerr_first_cause", Error_Cause, ERR_MEM);
        checkOutput("memerr_first_addr", Error_Address, 32'h7FFF);
        applyStimulus(1'b0, 1'b0, 32'h8000, 32'h0, 2, 1'b1, 32'h22222222, 1'b0, "memerr_second");
        checkOutput("memerr_second_addr", Error_Address, 32'h7FFF);
        checkOutput("memerr_second_flag", Error_Flag, 1'b1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                contend($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                        $urandom_range(0, 4), $sformatf("rnd%0d_arb", i));
            end else begin
                bit isData;
                bit wr;
                int waits;
                bit memErr;
                isData = 1'($urandom_range(0, 1));
                wr     = 1'($urandom_range(0, 1));
                waits  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
                memErr = (waits >= 0) && ($urandom_range(0, 5) == 0);
                applyStimulus(isData, wr, $urandom, $urandom, waits, memErr, $urandom,
                              1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
